// File: rtl/kstep_pkg.sv
// Shared constants for the step/dir move queue.
// Moves are packed as {dir, add, count, interval}, interval in the LSBs.
package kstep_pkg;

  localparam int DEF_INTERVAL_W = 16;
  localparam int DEF_COUNT_W    = 16;
  localparam int DEF_ADD_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_PULSE_W    = 8;
  localparam int DEF_POS_W      = 32;

  localparam int MIN_INTERVAL = 2;

  localparam int IV_OFF  = 0;
  localparam int CNT_OFF = IV_OFF + DEF_INTERVAL_W;
  localparam int ADD_OFF = CNT_OFF + DEF_COUNT_W;
  localparam int DIR_OFF = ADD_OFF + DEF_ADD_W;
  localparam int MOVE_W  = DIR_OFF + 1;

  function automatic int move_width(input int iw, input int cw, input int aw);
    return iw + cw + aw + 1;
  endfunction

endpackage

// File: rtl/kstep_move_fifo.sv
// Synchronous move queue with occupancy level.
// Pointers carry an extra wrap bit so full and empty are distinct.
module kstep_move_fifo
  import kstep_pkg::*;
#(
  parameter int W     = MOVE_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/kstep_step_queue.sv
// Step/dir pulse generator driven by a queue of timed moves.
// Moves chain back-to-back; position tracks every emitted step.
module kstep_step_queue
  import kstep_pkg::*;
#(
  parameter int INTERVAL_W = DEF_INTERVAL_W,
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int ADD_W      = DEF_ADD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int POS_W      = DEF_POS_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [INTERVAL_W-1:0]       cmd_interval,
  input  logic [COUNT_W-1:0]          cmd_count,
  input  logic [ADD_W-1:0]            cmd_add,
  input  logic                        cmd_dir,
  input  logic [PULSE_W-1:0]          pulse_ticks,
  input  logic                        dir_invert,
  output logic                        step,
  output logic                        dir,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [POS_W-1:0]            position
);

  localparam int MW     = move_width(INTERVAL_W, COUNT_W, ADD_W);
  localparam int CNT_LO = INTERVAL_W;
  localparam int ADD_LO = INTERVAL_W + COUNT_W;
  localparam int CW     = (INTERVAL_W > PULSE_W) ? INTERVAL_W : PULSE_W;

  logic [MW-1:0] push_data, head;
  logic          push, pop, empty, full;

  assign push_data = {cmd_dir, cmd_add, cmd_count, cmd_interval};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  kstep_move_fifo #(
    .W     (MW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full),
    .level_o (fifo_level)
  );

  logic [INTERVAL_W-1:0] h_iv;
  logic [COUNT_W-1:0]    h_cnt;
  logic [ADD_W-1:0]      h_add;
  logic                  h_dir, head_ok;

  assign h_iv    = head[INTERVAL_W-1:0];
  assign h_cnt   = head[CNT_LO +: COUNT_W];
  assign h_add   = head[ADD_LO +: ADD_W];
  assign h_dir   = head[MW-1];
  assign head_ok = !empty && (h_cnt != '0);

  logic                  active_q, active_d;
  logic [COUNT_W-1:0]    remaining_q, remaining_d;
  logic [INTERVAL_W-1:0] cur_iv_q, cur_iv_d;
  logic [ADD_W-1:0]      add_q, add_d;
  logic [INTERVAL_W-1:0] timer_q, timer_d;
  logic                  dir_reg_q, dir_reg_d;
  logic                  step_q, step_d;
  logic [PULSE_W-1:0]    pulse_q, pulse_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_q, dir_d;

  logic [INTERVAL_W-1:0] iv_next, reload;
  logic [PULSE_W-1:0]    pt1;

  assign pt1     = (pulse_ticks == '0) ? PULSE_W'(1) : pulse_ticks;
  assign iv_next = cur_iv_q + INTERVAL_W'($signed(add_q));

  function automatic logic [INTERVAL_W-1:0] clamp_iv(
    input logic [INTERVAL_W-1:0] v
  );
    return (v < INTERVAL_W'(MIN_INTERVAL)) ? INTERVAL_W'(MIN_INTERVAL) : v;
  endfunction

  // High time is capped so at least one low clock precedes the next step.
  function automatic logic [PULSE_W-1:0] pulse_len(
    input logic [INTERVAL_W-1:0] rl
  );
    logic [CW-1:0] lim;
    lim = CW'(rl) - CW'(1);
    return (CW'(pt1) <= lim) ? pt1 : PULSE_W'(lim);
  endfunction

  always_comb begin
    active_d    = active_q;
    remaining_d = remaining_q;
    cur_iv_d    = cur_iv_q;
    add_d       = add_q;
    timer_d     = timer_q;
    dir_reg_d   = dir_reg_q;
    step_d      = step_q;
    pulse_d     = pulse_q;
    pos_d       = pos_q;
    pop         = 1'b0;
    reload      = clamp_iv(iv_next);
    if (en) begin
      if (step_q) begin
        if (pulse_q <= PULSE_W'(1)) step_d  = 1'b0;
        else                        pulse_d = pulse_q - PULSE_W'(1);
      end
      if (active_q) begin
        if (timer_q == INTERVAL_W'(1)) begin
          step_d      = 1'b1;
          pos_d       = dir_reg_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          remaining_d = remaining_q - COUNT_W'(1);
          cur_iv_d    = iv_next;
          timer_d     = reload;
          if (remaining_q == COUNT_W'(1)) begin
            active_d = 1'b0;
            if (!empty) begin
              pop = 1'b1;
              if (head_ok) begin
                active_d    = 1'b1;
                remaining_d = h_cnt;
                cur_iv_d    = h_iv;
                add_d       = h_add;
                timer_d     = clamp_iv(h_iv);
                dir_reg_d   = h_dir;
                reload      = clamp_iv(h_iv);
              end
            end
          end
          pulse_d = pulse_len(reload);
        end else begin
          timer_d = timer_q - INTERVAL_W'(1);
        end
      end else if (!step_q && !empty) begin
        pop = 1'b1;
        if (head_ok) begin
          active_d    = 1'b1;
          remaining_d = h_cnt;
          cur_iv_d    = h_iv;
          add_d       = h_add;
          timer_d     = clamp_iv(h_iv);
          dir_reg_d   = h_dir;
        end
      end
    end
    dir_d = step_d ? dir_q : (dir_reg_q ^ dir_invert);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= 1'b0;
      remaining_q <= '0;
      cur_iv_q    <= '0;
      add_q       <= '0;
      timer_q     <= '0;
      dir_reg_q   <= 1'b0;
      step_q      <= 1'b0;
      pulse_q     <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
    end else begin
      active_q    <= active_d;
      remaining_q <= remaining_d;
      cur_iv_q    <= cur_iv_d;
      add_q       <= add_d;
      timer_q     <= timer_d;
      dir_reg_q   <= dir_reg_d;
      step_q      <= step_d;
      pulse_q     <= pulse_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign busy     = active_q || !empty || step_q;
  assign position = pos_q;

endmodule

// File: tb/tb_kstep_step_queue.sv
// Directed bench for kstep_step_queue: vector table plus multi-cycle
// sequences for chaining, queue backpressure, enable freeze and reset.
module tb_kstep_step_queue;

  logic        clk = 1'b0;
  logic        rst, en, cmd_valid, cmd_ready, cmd_dir;
  logic        dir_invert, step, dir, busy;
  logic [15:0] cmd_interval, cmd_count, cmd_add;
  logic [7:0]  pulse_ticks;
  logic [2:0]  fifo_level;
  logic [31:0] position;

  always #5 clk = ~clk;

  kstep_step_queue dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_interval (cmd_interval),
    .cmd_count    (cmd_count),
    .cmd_add      (cmd_add),
    .cmd_dir      (cmd_dir),
    .pulse_ticks  (pulse_ticks),
    .dir_invert   (dir_invert),
    .step         (step),
    .dir          (dir),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .position     (position)
  );

  int   total = 0;
  int   bad = 0;
  int   tcnt = 0;
  int   nrise = 0;
  int   rise_t [32];
  int   high_t [32];
  int   dir_at_rise [32];
  int   dir_fall_t = -1;
  logic prev_s = 1'b0;
  logic prev_d = 1'b0;
  int   exp_pos = 0;

  // tcnt=k samples the state left by the k-th edge after mon_start
  always @(negedge clk) begin
    tcnt++;
    if (step && !prev_s && nrise < 32) begin
      rise_t[nrise] = tcnt;
      high_t[nrise] = 0;
      dir_at_rise[nrise] = int'(dir);
      nrise++;
    end
    if (step && nrise > 0) high_t[nrise-1]++;
    if (prev_d && !dir) dir_fall_t = tcnt;
    prev_s = step;
    prev_d = dir;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic mon_start();
    tcnt = -1;
    nrise = 0;
    dir_fall_t = -1;
    prev_s = step;
    prev_d = dir;
  endtask

  task automatic push(input int iv, input int cnt, input int add,
                      input bit d, output int waits);
    cmd_interval = 16'(iv);
    cmd_count    = 16'(cnt);
    cmd_add      = 16'(add);
    cmd_dir      = d;
    cmd_valid    = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 500) begin
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, longint'(busy), 0);
  endtask

  typedef struct {
    int iv;
    int cnt;
    int add;
    bit d;
    int pt;
    bit inv;
    int r [4];
    int hi;
  } vec_t;

  vec_t vt [6];

  task automatic setv(input int i, input int iv, input int cnt, input int add,
                      input bit d, input int pt, input bit inv,
                      input int r0, input int r1, input int r2, input int r3,
                      input int hi);
    vt[i].iv = iv;  vt[i].cnt = cnt; vt[i].add = add;
    vt[i].d = d;    vt[i].pt = pt;   vt[i].inv = inv;
    vt[i].r[0] = r0; vt[i].r[1] = r1; vt[i].r[2] = r2; vt[i].r[3] = r3;
    vt[i].hi = hi;
  endtask

  initial begin
    int w;
    rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_interval = '0; cmd_count = '0; cmd_add = '0;
    pulse_ticks = 8'd2; dir_invert = 1'b0;

    setv(0, 10, 3,  0, 1, 2, 0, 11, 21, 31,  0, 2);
    setv(1, 20, 4, -5, 0, 2, 0, 21, 36, 46, 51, 2);
    setv(2, 20, 4, -5, 0, 2, 1, 21, 36, 46, 51, 2);
    setv(3,  1, 2,  0, 1, 5, 0,  3,  5,  0,  0, 1);
    setv(4,  3, 2,  0, 1, 0, 0,  4,  7,  0,  0, 1);
    setv(5,  6, 3,  2, 1, 9, 0,  7, 15, 25,  0, 7);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_step", longint'(step), 0);
    chk("rst_dir", longint'(dir), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ready", longint'(cmd_ready), 1);
    chk("rst_level", longint'(fifo_level), 0);
    chk("rst_pos", longint'($signed(position)), 0);

    for (int i = 0; i < 6; i++) begin
      pulse_ticks = 8'(vt[i].pt);
      dir_invert  = vt[i].inv;
      @(posedge clk); #1;
      push(vt[i].iv, vt[i].cnt, vt[i].add, vt[i].d, w);
      mon_start();
      wait_idle($sformatf("v%0d_idle", i), 600);
      exp_pos += vt[i].d ? vt[i].cnt : -vt[i].cnt;
      chk($sformatf("v%0d_nsteps", i), nrise, vt[i].cnt);
      for (int j = 0; j < vt[i].cnt; j++)
        chk($sformatf("v%0d_rise%0d", i, j), rise_t[j], vt[i].r[j]);
      chk($sformatf("v%0d_high", i), high_t[0], vt[i].hi);
      chk($sformatf("v%0d_dirpin", i), dir_at_rise[0],
          int'(vt[i].d ^ vt[i].inv));
      chk($sformatf("v%0d_pos", i), longint'($signed(position)), exp_pos);
    end

    // back-to-back moves with a direction change
    pulse_ticks = 8'd2;
    dir_invert  = 1'b0;
    @(posedge clk); #1;
    push(8, 2, 0, 1'b1, w);
    mon_start();
    push(12, 2, 0, 1'b0, w);
    wait_idle("chain_idle", 300);
    chk("chain_n", nrise, 4);
    chk("chain_r0", rise_t[0], 9);
    chk("chain_r1", rise_t[1], 17);
    chk("chain_r2", rise_t[2], 29);
    chk("chain_r3", rise_t[3], 41);
    chk("chain_dirfall", dir_fall_t, 19);
    chk("chain_pos", longint'($signed(position)), exp_pos);

    // fill the queue behind a running move, one zero-count entry
    push(30, 2, 0, 1'b1, w);
    mon_start();
    push(5, 1, 0, 1'b1, w);
    push(7, 0, 0, 1'b1, w);
    push(5, 1, 0, 1'b1, w);
    push(5, 1, 0, 1'b1, w);
    chk("fill_level", longint'(fifo_level), 4);
    chk("fill_ready", longint'(cmd_ready), 0);
    chk("fill_busy", longint'(busy), 1);
    push(5, 1, 0, 1'b1, w);
    chk("fill_stall", w, 57);
    wait_idle("fill_idle", 600);
    exp_pos += 6;
    chk("fill_n", nrise, 6);
    chk("fill_chain", rise_t[2], 66);
    chk("fill_pos", longint'($signed(position)), exp_pos);

    // enable dropped for 7 clocks in the middle of the first pulse
    pulse_ticks = 8'd3;
    push(10, 2, 0, 1'b1, w);
    mon_start();
    repeat (11) @(posedge clk);
    #1;
    chk("en_step_hi", longint'(step), 1);
    en = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    en = 1'b1;
    wait_idle("en_idle", 300);
    exp_pos += 2;
    chk("en_n", nrise, 2);
    chk("en_r0", rise_t[0], 11);
    chk("en_r1", rise_t[1], 28);
    chk("en_h0", high_t[0], 10);
    chk("en_h1", high_t[1], 3);
    chk("en_pos", longint'($signed(position)), exp_pos);

    // reset during a pulse of a long move
    pulse_ticks = 8'd4;
    push(50, 100, 0, 1'b1, w);
    push(5, 1, 0, 1'b1, w);
    begin
      int k;
      for (k = 0; k < 120; k++) begin
        @(negedge clk);
        if (step) break;
      end
      chk("rst_wait_step", longint'(step), 1);
    end
    chk("rst_pre_level", longint'(fifo_level), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstm_step", longint'(step), 0);
    chk("rstm_busy", longint'(busy), 0);
    chk("rstm_pos", longint'($signed(position)), 0);
    chk("rstm_level", longint'(fifo_level), 0);
    chk("rstm_ready", longint'(cmd_ready), 1);
    chk("rstm_dir", longint'(dir), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rstm_after_busy", longint'(busy), 0);
    chk("rstm_after_pos", longint'($signed(position)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
